// File: rtl/spi_pkg.sv
// Shared types for the SPI master engine.
// FSM state encoding and the per-transfer mode bundle.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_s;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timing for the SPI master: half-period divider,
// lead/trail edge strobes and the phase terminal count.
module spi_clk_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             run_i,
  input  logic             xfer_i,
  output logic             lead_o,
  output logic             trail_o,
  output logic             tc_o
);

  localparam int EW = $clog2(2 * DATA_W);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W:0]   cnt_q;
  logic [EW-1:0]    edge_q;
  logic             tick;
  logic             last;

  assign tick    = run_i && (cnt_q == '0);
  assign last    = edge_q == EW'(2 * DATA_W - 1);
  assign lead_o  = tick && xfer_i && !edge_q[0];
  assign trail_o = tick && xfer_i && edge_q[0];
  assign tc_o    = tick && (!xfer_i || last);

  // SETUP gets one extra cycle: the accept cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      cnt_q  <= '0;
      edge_q <= '0;
    end else if (start_i) begin
      div_q  <= div_i;
      cnt_q  <= {1'b0, div_i} + (DIV_W + 1)'(1);
      edge_q <= '0;
    end else if (tick) begin
      cnt_q <= {1'b0, div_q};
      if (xfer_i) edge_q <= edge_q + EW'(1);
    end else if (run_i) begin
      cnt_q <= cnt_q - (DIV_W + 1)'(1);
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// SPI master engine: one DATA_W-bit full-duplex word per start,
// runtime CPOL/CPHA, bit order, divider and slave select.
module spi_master_core
  import spi_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  NUM_SS = 4,
  parameter int  DIV_W  = 8,
  // one spare code so an out-of-range select is expressible
  localparam int SEL_W  = $clog2(NUM_SS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [SEL_W-1:0]  ss_sel_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DIV_W-1:0]  clk_div_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_SS-1:0] ss_n_o
);

  spi_state_e        state_q;
  spi_mode_s         mode_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [NUM_SS-1:0] ss_n_q;
  logic [NUM_SS-1:0] ss_dec;
  logic              sclk_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;
  logic              lead;
  logic              trail;
  logic              tc;
  logic              smp;
  logic              shf;

  function automatic logic head(
    input logic [DATA_W-1:0] w,
    input logic              lsb
  );
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] adv(
    input logic [DATA_W-1:0] w,
    input logic              lsb
  );
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] push(
    input logic [DATA_W-1:0] w,
    input logic              b,
    input logic              lsb
  );
    return lsb ? {b, w[DATA_W-1:1]}
               : {w[DATA_W-2:0], b};
  endfunction

  assign accept = start_i && (state_q == IDLE);
  assign smp    = mode_q.cpha ? trail : lead;
  // the final trailing edge ends the word, no new bit
  assign shf    = mode_q.cpha ? lead : (trail && !tc);

  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (ss_sel_i == SEL_W'(i)) ss_dec[i] = 1'b0;
  end

  spi_clk_gen #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .div_i   (clk_div_i),
    .run_i   (state_q != IDLE),
    .xfer_i  (state_q == XFER),
    .lead_o  (lead),
    .trail_o (trail),
    .tc_o    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      ss_n_q    <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          mode_q.cpol      <= cpol_i;
          mode_q.cpha      <= cpha_i;
          mode_q.lsb_first <= lsb_first_i;
          sclk_q  <= cpol_i;
          ss_n_q  <= ss_dec;
          busy_q  <= 1'b1;
          rx_q    <= '0;
          state_q <= SETUP;
          if (cpha_i) begin
            tx_q <= tx_data_i;
          end else begin
            mosi_q <= head(tx_data_i, lsb_first_i);
            tx_q   <= adv(tx_data_i, lsb_first_i);
          end
        end
        SETUP: if (tc) state_q <= XFER;
        XFER: begin
          if (lead || trail) sclk_q <= ~sclk_q;
          if (smp)
            rx_q <= push(rx_q, miso_i, mode_q.lsb_first);
          if (shf) begin
            mosi_q <= head(tx_q, mode_q.lsb_first);
            tx_q   <= adv(tx_q, mode_q.lsb_first);
          end
          if (tc) state_q <= HOLD;
        end
        HOLD: if (tc) begin
          state_q   <= IDLE;
          sclk_q    <= mode_q.cpol;
          ss_n_q    <= '1;
          mosi_q    <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          rx_data_q <= rx_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign ss_n_o    = ss_n_q;

endmodule
